// File: rtl/data_mem_arb_pkg.sv
// Shared types and sizing helpers for the data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: round-robin starting at i_ptr, or fixed
// priority (lowest index wins) when FIXED_PRIO is set.
module rr_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int N          = 2,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int IW         = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any_grant
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = FIXED_PRIO ? IW'(k) : IW'((int'(i_ptr) + k) % N);
            if (!o_any_grant && i_req[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises N DataMemory-style masters onto one single-ported memory,
// stalling each master until its write is taken or its read data returns.
//
//   state        | meaning
//   ST_IDLE      | arbitrate; writes complete here, a read grant moves on
//   ST_READ_WAIT | memory busy with one read; count down to data return
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_PORTS-1:0]               m_en,
    input  logic [N_PORTS-1:0]               m_we,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]   m_addr,
    input  logic [N_PORTS-1:0][DATA_W-1:0]   m_wd,
    output logic [N_PORTS-1:0][DATA_W-1:0]   m_rd,
    output logic [N_PORTS-1:0]               m_stall,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wd,
    input  logic [DATA_W-1:0]                mem_rd
);

    localparam int            IW  = idx_width(N_PORTS);
    localparam int            CW  = cnt_width(RD_LATENCY);
    localparam logic [CW-1:0] LAT = CW'(RD_LATENCY);

    arb_state_e                       r_state;
    arb_state_e                       w_state_nxt;
    logic [IW-1:0]                    r_ptr;
    logic [IW-1:0]                    r_owner;
    logic [CW-1:0]                    r_cnt;
    logic [N_PORTS-1:0][DATA_W-1:0]   r_rd_hold;

    logic [N_PORTS-1:0]               w_grant;
    logic [IW-1:0]                    w_gidx;
    logic                             w_any;
    logic [IW-1:0]                    w_ptr_nxt;
    logic [N_PORTS-1:0]               w_done;
    logic                             w_rd_done;

    rr_arbiter #(
        .N          (N_PORTS),
        .FIXED_PRIO (FIXED_PRIO),
        .IW         (IW)
    ) u_arb (
        .i_req       (m_en),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any_grant (w_any)
    );

    assign w_ptr_nxt = (int'(w_gidx) == N_PORTS - 1) ? '0 : w_gidx + 1'b1;

    // Everything is gated by reset so all requesters read as stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = '0;
        w_rd_done   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wd      = '0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        mem_en   = 1'b1;
                        mem_we   = m_we[w_gidx];
                        mem_addr = m_addr[w_gidx];
                        mem_wd   = m_wd[w_gidx];
                        w_done   = w_grant & m_we;
                        if (!m_we[w_gidx]) begin
                            w_state_nxt = ST_READ_WAIT;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        w_rd_done       = 1'b1;
                        w_done[r_owner] = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_stall = m_en & ~w_done;
        for (int i = 0; i < N_PORTS; i++) begin
            m_rd[i] = (w_rd_done && r_owner == IW'(i)) ? mem_rd : r_rd_hold[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_owner   <= '0;
            r_rd_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                if (!FIXED_PRIO) begin
                    r_ptr <= w_ptr_nxt;
                end
                if (!m_we[w_gidx]) begin
                    r_owner <= w_gidx;
                    r_cnt   <= LAT;
                end
            end else if (r_state == ST_READ_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_done) begin
                r_rd_hold[r_owner] <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: A = 2 ports / latency 2 / round-robin,
// B = 3 ports / latency 3 / fixed priority, each with a simple BRAM model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // ---------------- DUT A ----------------
    logic             a_reset;
    logic [1:0]       a_en, a_we, a_stall;
    logic [1:0][31:0] a_addr, a_wd, a_rd;
    logic             a_mem_en, a_mem_we;
    logic [31:0]      a_mem_addr, a_mem_wd, a_mem_rd;
    logic [31:0]      mem_a [256];
    logic [31:0]      pipe_a [2];

    data_mem_arbiter #(
        .N_PORTS(2), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(2), .FIXED_PRIO(1'b0)
    ) dut_a (
        .clk(clk), .reset(a_reset),
        .m_en(a_en), .m_we(a_we), .m_addr(a_addr), .m_wd(a_wd),
        .m_rd(a_rd), .m_stall(a_stall),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
    );

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wd;
        pipe_a[0] <= mem_a[a_mem_addr[7:0]];
        pipe_a[1] <= pipe_a[0];
    end
    assign a_mem_rd = pipe_a[1];

    // ---------------- DUT B ----------------
    logic             b_reset;
    logic [2:0]       b_en, b_we, b_stall;
    logic [2:0][31:0] b_addr, b_wd, b_rd;
    logic             b_mem_en, b_mem_we;
    logic [31:0]      b_mem_addr, b_mem_wd, b_mem_rd;
    logic [31:0]      mem_b [256];
    logic [31:0]      pipe_b [3];

    data_mem_arbiter #(
        .N_PORTS(3), .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .FIXED_PRIO(1'b1)
    ) dut_b (
        .clk(clk), .reset(b_reset),
        .m_en(b_en), .m_we(b_we), .m_addr(b_addr), .m_wd(b_wd),
        .m_rd(b_rd), .m_stall(b_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wd;
        pipe_b[0] <= mem_b[b_mem_addr[7:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_mem_rd = pipe_b[2];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int p, input bit w, input logic [31:0] ad,
                          input logic [31:0] d, input int c);
        exp_t e;
        e.port = p; e.is_wr = w; e.addr = ad; e.data = d; e.cyc = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input int p, input bit w, input logic [31:0] ad,
                          input logic [31:0] d, input int c);
        exp_t e;
        e.port = p; e.is_wr = w; e.addr = ad; e.data = d; e.cyc = c;
        qb.push_back(e);
    endtask

    // Hold a request until it completes, then release it one edge later.
    task automatic a_req(input int p, input bit we, input logic [31:0] ad, input logic [31:0] wd);
        int n;
        n = 0;
        a_en[p] = 1'b1; a_we[p] = we; a_addr[p] = ad; a_wd[p] = wd;
        do begin
            @(negedge clk);
            n++;
        end while (a_stall[p] && n < 40);
        if (a_stall[p]) begin
            total++; bad++;
            $display("FAIL a_timeout: port %0d still stalled after %0d cycles, required completion", p, n);
        end
        @(posedge clk); #1;
        a_en[p] = 1'b0;
    endtask

    task automatic b_req(input int p, input bit we, input logic [31:0] ad, input logic [31:0] wd);
        int n;
        n = 0;
        b_en[p] = 1'b1; b_we[p] = we; b_addr[p] = ad; b_wd[p] = wd;
        do begin
            @(negedge clk);
            n++;
        end while (b_stall[p] && n < 40);
        if (b_stall[p]) begin
            total++; bad++;
            $display("FAIL b_timeout: port %0d still stalled after %0d cycles, required completion", p, n);
        end
        @(posedge clk); #1;
        b_en[p] = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!a_reset) begin
            for (int i = 0; i < 2; i++) begin
                if (a_en[i] && !a_stall[i]) begin
                    if (qa.size() == 0) begin
                        total++; bad++;
                        $display("FAIL a_unexpected: port %0d completed at cycle %0d, required none", i, cyc);
                    end else begin
                        ea = qa.pop_front();
                        chk("a_port", i, ea.port);
                        chk("a_cycle", cyc, ea.cyc);
                        if (ea.is_wr) begin
                            chk("a_mem_we", a_mem_we, 1);
                            chk("a_mem_addr", a_mem_addr, ea.addr);
                            chk("a_mem_wd", a_mem_wd, ea.data);
                        end else begin
                            chk("a_rd", a_rd[i], ea.data);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!b_reset) begin
            for (int i = 0; i < 3; i++) begin
                if (b_en[i] && !b_stall[i]) begin
                    if (qb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected: port %0d completed at cycle %0d, required none", i, cyc);
                    end else begin
                        eb = qb.pop_front();
                        chk("b_port", i, eb.port);
                        chk("b_cycle", cyc, eb.cyc);
                        if (eb.is_wr) begin
                            chk("b_mem_we", b_mem_we, 1);
                            chk("b_mem_addr", b_mem_addr, eb.addr);
                            chk("b_mem_wd", b_mem_wd, eb.data);
                        end else begin
                            chk("b_rd", b_rd[i], eb.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        a_reset = 1'b1; a_en = '0; a_we = '0; a_addr = '0; a_wd = '0;
        b_reset = 1'b1; b_en = '0; b_we = '0; b_addr = '0; b_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        a_en = 2'b11;
        @(negedge clk);
        chk("a_rst_stall", a_stall, 2'b11);
        chk("a_rst_mem_en", a_mem_en, 0);
        chk("a_rst_mem_we", a_mem_we, 0);
        chk("a_rst_mem_addr", a_mem_addr, 0);
        chk("a_rst_rd", a_rd, 0);
        @(posedge clk); #1;
        a_en = '0;
        a_reset = 1'b0;

        // single write then single read
        push_a(0, 1, 32'h10, 32'hDEADBEEF, cyc);
        a_req(0, 1, 32'h10, 32'hDEADBEEF);
        push_a(0, 0, 32'h10, 32'hDEADBEEF, cyc + 2);
        fork
            a_req(0, 0, 32'h10, 32'h0);
            begin
                @(negedge clk); chk("a_rd_stall_t0", a_stall[0], 1);
                @(negedge clk); chk("a_rd_stall_t1", a_stall[0], 1);
            end
        join

        // port1 write leaves the pointer at 0
        push_a(1, 1, 32'h20, 32'h1234, cyc);
        a_req(1, 1, 32'h20, 32'h1234);

        // simultaneous reads, round-robin
        c = cyc;
        push_a(0, 0, 32'h10, 32'hDEADBEEF, c + 2);
        push_a(1, 0, 32'h20, 32'h1234, c + 5);
        fork
            a_req(0, 0, 32'h10, 32'h0);
            a_req(1, 0, 32'h20, 32'h0);
            begin
                repeat (4) @(negedge clk);
                chk("a_p1_grant_en", a_mem_en, 1);
                chk("a_p1_grant_addr", a_mem_addr, 32'h20);
            end
        join

        // pointer back at 0: port0 must win the tie
        c = cyc;
        push_a(0, 1, 32'h30, 32'hA0, c);
        push_a(1, 1, 32'h31, 32'hB0, c + 1);
        fork
            a_req(0, 1, 32'h30, 32'hA0);
            a_req(1, 1, 32'h31, 32'hB0);
        join

        // interleaved write stream, one grant per cycle
        c = cyc;
        for (int j = 0; j < 4; j++) begin
            push_a(0, 1, 32'h40 + j, 32'h100 + j, c + 2 * j);
            push_a(1, 1, 32'h50 + j, 32'h200 + j, c + 2 * j + 1);
        end
        fork
            begin
                for (int j = 0; j < 4; j++) a_req(0, 1, 32'h40 + j, 32'h100 + j);
            end
            begin
                for (int j = 0; j < 4; j++) a_req(1, 1, 32'h50 + j, 32'h200 + j);
            end
        join

        // read hold data persists while another port reads
        push_a(1, 0, 32'h20, 32'h1234, cyc + 2);
        a_req(1, 0, 32'h20, 32'h0);
        c = cyc;
        push_a(0, 0, 32'h40, 32'h100, c + 2);
        push_a(0, 0, 32'h41, 32'h101, c + 5);
        fork
            begin
                a_req(0, 0, 32'h40, 32'h0);
                a_req(0, 0, 32'h41, 32'h0);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("a_rd_hold1", a_rd[1], 32'h1234);
                end
            end
        join

        // ---------------- DUT B ----------------
        b_en = 3'b111;
        @(negedge clk);
        chk("b_rst_stall", b_stall, 3'b111);
        chk("b_rst_mem_en", b_mem_en, 0);
        @(posedge clk); #1;
        b_en = '0;
        b_reset = 1'b0;

        // fixed priority: port0 streams writes, 1 then 2 wait
        c = cyc;
        for (int j = 0; j < 4; j++) push_b(0, 1, 32'h60 + j, 32'h300 + j, c + j);
        push_b(1, 0, 32'h60, 32'h300, c + 7);
        push_b(2, 0, 32'h61, 32'h301, c + 11);
        fork
            begin
                for (int j = 0; j < 4; j++) b_req(0, 1, 32'h60 + j, 32'h300 + j);
            end
            b_req(1, 0, 32'h60, 32'h0);
            b_req(2, 0, 32'h61, 32'h0);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("b_fixed_stall", b_stall[2:1], 2'b11);
                end
            end
        join

        // give port0 non-zero hold data, then abort a read with reset
        push_b(0, 0, 32'h61, 32'h301, cyc + 3);
        b_req(0, 0, 32'h61, 32'h0);
        b_en[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 32'h60;
        @(negedge clk);
        chk("b_abort_grant", b_mem_en, 1);
        @(posedge clk); #1;
        b_reset = 1'b1;
        b_en[0] = 1'b0;
        @(posedge clk); #1;
        b_reset = 1'b0;
        @(negedge clk);
        chk("b_after_rst_rd0", b_rd[0], 0);
        chk("b_after_rst_mem_en", b_mem_en, 0);
        @(posedge clk); #1;
        push_b(0, 0, 32'h62, 32'h302, cyc + 3);
        fork
            b_req(0, 0, 32'h62, 32'h0);
            begin
                @(negedge clk);
                chk("b_new_grant", b_mem_en, 1);
            end
        join

        repeat (5) @(posedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
